// File: rtl/loader_pkg.sv
// Shared definitions for the instruction debug loader: FSM encodings,
// UART command bytes and instruction-word defaults.
package loader_pkg;

    localparam int NB_DATA    = 32;
    localparam int IMEM_DEPTH = 64;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_RESTART = 3'd2;
    localparam state_t ST_RUN     = 3'd3;
    localparam state_t ST_STEP    = 3'd4;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

endpackage

// File: rtl/instr_debug_loader_assembler.sv
// byte_word_assembler: shifts received bytes MSB-first into a 32-bit word and
// flags, combinationally, the strobe that completes the 4th byte.
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [7:0]         i_byte,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_ready
);

    logic [NB_DATA-1:0] r_word;
    logic [1:0]         r_idx;

    // Next word value and completion flag for the byte currently on the input.
    always_comb begin
        o_word       = {r_word[NB_DATA-9:0], i_byte};
        o_word_ready = i_valid && (r_idx == 2'd3);
    end

    // Shift register and byte index; a clear drops any partial word.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= {NB_DATA{1'b0}};
            r_idx  <= 2'd0;
        end else if (i_clear) begin
            r_word <= {NB_DATA{1'b0}};
            r_idx  <= 2'd0;
        end else if (i_valid) begin
            r_word <= o_word;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_word <= r_word;
            r_idx  <= r_idx;
        end
    end

endmodule

// File: rtl/instr_debug_loader.sv
// UART-driven instruction loader and run/step controller for the pipeline.
// Optional inter-byte LOAD timeout is enabled with LOADER_TIMEOUT_EN.
module instr_debug_loader #(
    parameter int                 NB_DATA        = loader_pkg::NB_DATA,
    parameter int                 IMEM_DEPTH     = loader_pkg::IMEM_DEPTH,
    parameter logic [NB_DATA-1:0] HALT_WORD      = loader_pkg::HALT_WORD,
    parameter int                 TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx_valid,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_pipe_end,
    output logic                          o_we_IF,
    output logic [NB_DATA-1:0]            o_instruction_data,
    output logic                          o_pipe_rst_n,
    output logic                          o_halt,
    output logic [2:0]                    o_state,
    output logic [$clog2(IMEM_DEPTH):0]   o_instr_count,
    output logic                          o_err
);
    import loader_pkg::*;

    localparam int CNT_W = $clog2(IMEM_DEPTH) + 1;

    state_t             r_state;
    logic               r_we;
    logic [NB_DATA-1:0] r_data;
    logic               r_pipe_rst_n;
    logic               r_halt;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;
    logic               r_rst_cnt;
    logic               r_done;
    logic               r_done_err;

    logic               w_clear;
    logic               w_byte_en;
    logic [NB_DATA-1:0] w_word;
    logic               w_word_ready;
    logic               w_timeout;

    // Assembler only listens in LOAD; once the load is finishing, extra bytes are dropped.
    always_comb begin
        w_clear   = (r_state != ST_LOAD);
        w_byte_en = i_rx_valid && (r_state == ST_LOAD) && !r_done;
    end

    byte_word_assembler u_asm (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_clear),
        .i_valid      (w_byte_en),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Idle-cycle counter; restarts on every received byte and outside LOAD.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if ((r_state != ST_LOAD) || i_rx_valid) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive byte-less LOAD cycle.
    always_comb begin
        w_timeout = (r_state == ST_LOAD) && !i_rx_valid && !r_done &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end
`else
    // No timeout hardware: LOAD waits indefinitely.
    always_comb begin
        w_timeout = 1'b0;
    end
`endif

    // Main control FSM with registered outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_data       <= {NB_DATA{1'b0}};
            r_pipe_rst_n <= 1'b1;
            r_halt       <= 1'b1;
            r_count      <= {CNT_W{1'b0}};
            r_err        <= 1'b0;
            r_rst_cnt    <= 1'b0;
            r_done       <= 1'b0;
            r_done_err   <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_halt       <= 1'b1;
                    r_pipe_rst_n <= 1'b1;
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                r_state    <= ST_LOAD;
                                r_count    <= {CNT_W{1'b0}};
                                r_done     <= 1'b0;
                                r_done_err <= 1'b0;
                            end
                            CMD_RUN: begin
                                r_state <= ST_RUN;
                                r_halt  <= 1'b0;
                            end
                            CMD_STEP: begin
                                r_state <= ST_STEP;
                                r_halt  <= 1'b0;
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // The write cycle stays in LOAD; the exit is taken one cycle later.
                    if (r_done) begin
                        r_state      <= ST_RESTART;
                        r_pipe_rst_n <= 1'b0;
                        r_rst_cnt    <= 1'b0;
                        r_err        <= r_done_err;
                        r_done       <= 1'b0;
                    end else if (w_timeout) begin
                        r_state      <= ST_RESTART;
                        r_pipe_rst_n <= 1'b0;
                        r_rst_cnt    <= 1'b0;
                        r_err        <= 1'b1;
                    end else if (w_word_ready) begin
                        r_we    <= 1'b1;
                        r_data  <= w_word;
                        r_count <= r_count + CNT_W'(1);
                        if (w_word == HALT_WORD) begin
                            r_done     <= 1'b1;
                            r_done_err <= 1'b0;
                        end else if (r_count == CNT_W'(IMEM_DEPTH - 1)) begin
                            r_done     <= 1'b1;
                            r_done_err <= 1'b1;
                        end else begin
                            r_done     <= 1'b0;
                            r_done_err <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_RESTART: begin
                    r_halt <= 1'b1;
                    if (r_rst_cnt) begin
                        r_state      <= ST_IDLE;
                        r_pipe_rst_n <= 1'b1;
                        r_rst_cnt    <= 1'b0;
                    end else begin
                        r_rst_cnt <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_pipe_end) begin
                        r_state <= ST_IDLE;
                        r_halt  <= 1'b1;
                    end else begin
                        r_halt <= 1'b0;
                    end
                end
                ST_STEP: begin
                    r_state <= ST_IDLE;
                    r_halt  <= 1'b1;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_halt       <= 1'b1;
                    r_pipe_rst_n <= 1'b1;
                end
            endcase
        end
    end

    // Drive ports straight from the registers.
    always_comb begin
        o_we_IF            = r_we;
        o_instruction_data = r_data;
        o_pipe_rst_n       = r_pipe_rst_n;
        o_halt             = r_halt;
        o_state            = r_state;
        o_instr_count      = r_count;
        o_err              = r_err;
    end

endmodule
